// File: rtl/bsg_rx_decoder.sv
// bsg_rx_decoder: serial BSG frame receiver with byte FIFO and control/status/data registers
// on the shared register bus (WRITE_ENABLE=1 reads, WRITE_ENABLE=0 writes).
module bsg_rx_decoder #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    CLKS_PER_BIT = 16,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 8'h20
) (
    input  logic                  G_CLK_TX,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  WRITE_ENABLE,
    input  logic [DATA_WIDTH-1:0] ADDR_IN,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  RX_IRQ
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_WIDTH);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic [CW-1:0]         HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]         BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [CNTW-1:0]       DEPTH    = CNTW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] A_STAT   = BASE_ADDR + DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] A_DATA   = BASE_ADDR + DATA_WIDTH'(2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_n;
    logic                  rx_s1, rx_s2, rx_s3;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BW-1:0]         bit_idx, bit_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic                  par_bad, par_bad_n;
    logic                  push, set_fe, set_pe, set_ovr;
    logic                  en, par_en, overrun, par_err, frame_err;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CNTW-1:0]       count;
    logic                  full, not_empty, fall, rx;
    logic                  sel_ctrl, sel_stat, sel_data, pop, clr;
    logic [2:0]            cnt_sat;
    logic [DATA_WIDTH-1:0] status_v, ctrl_rb, dout_n;

    assign rx        = rx_s2;
    assign fall      = rx_s3 & ~rx_s2;
    assign full      = count == DEPTH;
    assign not_empty = count != '0;
    assign sel_ctrl  = ADDR_IN == BASE_ADDR;
    assign sel_stat  = ADDR_IN == A_STAT;
    assign sel_data  = ADDR_IN == A_DATA;
    assign pop       = WRITE_ENABLE & sel_data & not_empty;
    assign clr       = ~WRITE_ENABLE & sel_ctrl & DATA_IN[2];
    assign cnt_sat   = (32'(count) > 7) ? 3'd7 : 3'(count);
    assign status_v  = DATA_WIDTH'({cnt_sat, frame_err, par_err, overrun, full, not_empty});
    assign ctrl_rb   = DATA_WIDTH'({par_en, en});

    // Unmatched addresses and write cycles leave DATA_OUT untouched: the bus is shared.
    assign dout_n = !WRITE_ENABLE ? DATA_OUT :
                    sel_ctrl      ? ctrl_rb  :
                    sel_stat      ? status_v :
                    sel_data      ? (not_empty ? mem[rd_ptr] : '0) : DATA_OUT;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_n     = bit_idx;
        shift_n   = shift;
        par_bad_n = par_bad;
        push      = 1'b0;
        set_fe    = 1'b0;
        set_pe    = 1'b0;
        set_ovr   = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (fall) begin
                        state_n   = START;
                        par_bad_n = 1'b0;
                    end
                end
                START: if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx ? IDLE : DATA;
                end
                DATA: if (cnt == BIT_M1) begin
                    cnt_n   = '0;
                    shift_n = {rx, shift[DATA_WIDTH-1:1]};
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) state_n = par_en ? PARITY : STOP;
                end
                PARITY: if (cnt == BIT_M1) begin
                    cnt_n     = '0;
                    par_bad_n = ^{shift, rx};
                    state_n   = STOP;
                end
                STOP: if (cnt == BIT_M1) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    set_fe  = ~rx;
                    set_pe  = rx & par_bad;
                    // a pop in the same cycle frees a slot, so a full FIFO still accepts the byte
                    set_ovr = rx & ~par_bad & full & ~pop;
                    push    = rx & ~par_bad & ~(full & ~pop);
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge G_CLK_TX or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_s3   <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bad <= 1'b0;
        end else begin
            state   <= state_n;
            rx_s1   <= RX_IN;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            par_bad <= par_bad_n;
        end
    end

    // Flag set takes priority over a simultaneous CLR_ERR.
    always_ff @(posedge G_CLK_TX or negedge rst) begin
        if (!rst) begin
            en        <= 1'b0;
            par_en    <= 1'b0;
            overrun   <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            DATA_OUT  <= '0;
            RX_IRQ    <= 1'b0;
        end else begin
            if (!WRITE_ENABLE && sel_ctrl) {par_en, en} <= DATA_IN[1:0];
            overrun   <= set_ovr | (overrun & ~clr);
            par_err   <= set_pe | (par_err & ~clr);
            frame_err <= set_fe | (frame_err & ~clr);
            DATA_OUT  <= dout_n;
            RX_IRQ    <= not_empty | overrun | par_err | frame_err;
        end
    end

    always_ff @(posedge G_CLK_TX or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNTW'(push) - CNTW'(pop);
        end
    end
endmodule

// File: tb/tb_bsg_rx_decoder.sv
// tb_bsg_rx_decoder: directed checks of frame decode, FIFO, flags and register bus.
module tb_bsg_rx_decoder;
    logic       G_CLK_TX = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic       WRITE_ENABLE = 1'b1;
    logic [7:0] ADDR_IN = 8'h00;
    logic [7:0] DATA_IN = 8'h00;
    logic [7:0] DATA_OUT;
    logic       RX_IRQ;
    logic [7:0] rd_cap;
    int         n_assert = 0;
    int         n_fail = 0;

    localparam logic [7:0] CTRL = 8'h20, STAT = 8'h21, DAT = 8'h22;
    localparam int NO_RD = 1000;

    bsg_rx_decoder dut (
        .G_CLK_TX    (G_CLK_TX),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .WRITE_ENABLE(WRITE_ENABLE),
        .ADDR_IN     (ADDR_IN),
        .DATA_IN     (DATA_IN),
        .DATA_OUT    (DATA_OUT),
        .RX_IRQ      (RX_IRQ)
    );

    always #5 G_CLK_TX = ~G_CLK_TX;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge G_CLK_TX);
        WRITE_ENABLE = 1'b0;
        ADDR_IN = a;
        DATA_IN = d;
        @(negedge G_CLK_TX);
        WRITE_ENABLE = 1'b1;
        ADDR_IN = 8'h00;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge G_CLK_TX);
        WRITE_ENABLE = 1'b1;
        ADDR_IN = a;
        @(negedge G_CLK_TX);
        ADDR_IN = 8'h00;
        chk(tag, DATA_OUT, exp);
    endtask

    // One frame, 16 cycles per bit; optionally reads RX_DATA on cycle rd_at of the frame.
    task automatic send(input logic [7:0] d, input bit use_par, input bit par_bit,
                        input bit stop_bit, input int rd_at);
        logic [10:0] fb;
        int n;
        fb = '1;
        fb[0] = 1'b0;
        fb[8:1] = d;
        if (use_par) begin
            fb[9] = par_bit;
            fb[10] = stop_bit;
            n = 11;
        end else begin
            fb[9] = stop_bit;
            n = 10;
        end
        for (int c = 0; c < n * 16; c++) begin
            @(negedge G_CLK_TX);
            RX_IN = fb[c / 16];
            if (c == rd_at) begin
                WRITE_ENABLE = 1'b1;
                ADDR_IN = DAT;
            end
            if (c == rd_at + 1) begin
                ADDR_IN = 8'h00;
                rd_cap = DATA_OUT;
            end
        end
        @(negedge G_CLK_TX);
        RX_IN = 1'b1;
        repeat (4) @(negedge G_CLK_TX);
    endtask

    initial begin
        repeat (3) @(negedge G_CLK_TX);
        chk("rst_dout", DATA_OUT, 8'h00);
        chk("rst_irq", {7'b0, RX_IRQ}, 8'h00);
        rst = 1'b1;
        rd("rst_ctrl", CTRL, 8'h00);
        rd("rst_stat", STAT, 8'h00);

        wr(CTRL, 8'h01);
        rd("t1_ctrl", CTRL, 8'h01);
        send(8'hA5, 0, 0, 1, NO_RD);
        rd("t1_stat", STAT, 8'h21);
        chk("t1_irq", {7'b0, RX_IRQ}, 8'h01);
        rd("t1_unmatched", 8'h55, 8'h21);
        wr(STAT, 8'hFF);
        wr(8'h55, 8'h00);
        rd("t1_ctrl_kept", CTRL, 8'h01);
        rd("t1_data", DAT, 8'hA5);
        rd("t1_stat_empty", STAT, 8'h00);
        chk("t1_irq_clr", {7'b0, RX_IRQ}, 8'h00);

        wr(CTRL, 8'h03);
        rd("t2_ctrl", CTRL, 8'h03);
        send(8'h03, 1, 0, 1, NO_RD);
        rd("t2_par_ok", STAT, 8'h21);
        send(8'h03, 1, 1, 1, NO_RD);
        rd("t2_par_err", STAT, 8'h29);
        rd("t2_data", DAT, 8'h03);
        wr(CTRL, 8'h05);
        rd("t2_ctrl_clr", CTRL, 8'h01);
        rd("t2_stat_clr", STAT, 8'h00);

        for (int i = 1; i <= 5; i++) send(8'(i), 0, 0, 1, NO_RD);
        rd("t3_full_ovr", STAT, 8'h87);
        rd("t3_d1", DAT, 8'h01);
        rd("t3_d2", DAT, 8'h02);
        rd("t3_d3", DAT, 8'h03);
        rd("t3_d4", DAT, 8'h04);
        rd("t3_empty_rd", DAT, 8'h00);
        rd("t3_ovr_sticky", STAT, 8'h04);
        wr(CTRL, 8'h05);
        rd("t3_clr", STAT, 8'h00);

        send(8'h5A, 0, 0, 0, NO_RD);
        rd("t4_frame_err", STAT, 8'h10);
        chk("t4_irq", {7'b0, RX_IRQ}, 8'h01);
        wr(CTRL, 8'h05);
        rd("t4_clr", STAT, 8'h00);
        rd("t4_ctrl", CTRL, 8'h01);

        @(negedge G_CLK_TX);
        RX_IN = 1'b0;
        repeat (3) @(negedge G_CLK_TX);
        RX_IN = 1'b1;
        repeat (40) @(negedge G_CLK_TX);
        rd("t5_glitch", STAT, 8'h00);
        for (int c = 0; c < 64; c++) begin
            @(negedge G_CLK_TX);
            RX_IN = 1'b0;
        end
        wr(CTRL, 8'h00);
        RX_IN = 1'b1;
        repeat (200) @(negedge G_CLK_TX);
        rd("t5_en_off", STAT, 8'h00);
        wr(CTRL, 8'h01);

        send(8'h11, 0, 0, 1, NO_RD);
        send(8'h22, 0, 0, 1, NO_RD);
        send(8'h33, 0, 0, 1, NO_RD);
        send(8'h44, 0, 0, 1, NO_RD);
        rd("t6_full", STAT, 8'h83);
        send(8'h55, 0, 0, 1, 154);
        chk("t6_rd_at_stop", rd_cap, 8'h11);
        rd("t6_no_ovr", STAT, 8'h83);
        rd("t6_d2", DAT, 8'h22);
        rd("t6_d3", DAT, 8'h33);
        rd("t6_d4", DAT, 8'h44);
        rd("t6_d5", DAT, 8'h55);
        rd("t6_empty", STAT, 8'h00);

        send(8'h66, 0, 0, 1, NO_RD);
        rd("t6_pre_rst", STAT, 8'h21);
        for (int c = 0; c < 40; c++) begin
            @(negedge G_CLK_TX);
            RX_IN = 1'b0;
        end
        rst = 1'b0;
        @(negedge G_CLK_TX);
        chk("t6_rst_dout", DATA_OUT, 8'h00);
        chk("t6_rst_irq", {7'b0, RX_IRQ}, 8'h00);
        rst = 1'b1;
        RX_IN = 1'b1;
        repeat (40) @(negedge G_CLK_TX);
        rd("t6_rst_ctrl", CTRL, 8'h00);
        rd("t6_rst_stat", STAT, 8'h00);
        wr(CTRL, 8'h01);
        send(8'hC3, 0, 0, 1, NO_RD);
        rd("t6_post_stat", STAT, 8'h21);
        rd("t6_post_data", DAT, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
